// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: FSM states, Configuration bit
// indices and data width.
package uart_pkg;
  localparam int DATA_WIDTH   = 8;
  localparam int CFG_PAR_EN   = 0;
  localparam int CFG_PAR_TYPE = 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period edge counter plus sample-point strobe; UART_RX_MAJORITY_EN selects a 2-of-3
// vote around mid-bit (decision one cycle later) instead of a single mid-bit sample.
module uart_rx_sampler #(
  parameter int PRESCALE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic rx,
  output logic sample_valid,
  output logic sample_bit,
  output logic bit_end
);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] MID  = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // Held at zero while idle so the start-detection cycle is count 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (!run)         cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

  assign bit_end = (cnt == LAST);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] EARLY = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] LATE  = CW'(PRESCALE / 2 + 1);

  logic s_early, s_mid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else begin
      if (cnt == EARLY) s_early <= rx;
      if (cnt == MID)   s_mid   <= rx;
    end
  end

  assign sample_valid = (cnt == LATE);
  assign sample_bit   = (s_early & s_mid) | (s_early & rx) | (s_mid & rx);
`else
  assign sample_valid = (cnt == MID);
  assign sample_bit   = rx;
`endif
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 with optional even/odd parity, one-cycle DATA_VALID / error strobes.
// UART_RX_MAJORITY_EN enables 2-of-3 majority sampling in uart_rx_sampler.
module uart_rx
  import uart_pkg::*;
#(
  parameter int PRESCALE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [1:0]            Configuration,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  Parity_Error,
  output logic                  Stop_Error,
  output logic                  Busy
);
  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] ALL_BITS = 4'(DATA_WIDTH);

  logic rx_m, rx_s, rx_prev;
  uart_state_t state;
  logic start_det, run;
  logic sample_valid, sample_bit, bit_end;
  logic [1:0] cfg;
  logic [DATA_WIDTH-1:0] shreg;
  logic [3:0] bit_cnt;
  logic par_fail;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= RX_IN;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  assign start_det = (state == IDLE) && rx_prev && !rx_s;

  // Counter stops in the cycle the FSM decides to return to IDLE, so a new start lands on count 0.
  always_comb begin
    run = 1'b1;
    case (state)
      IDLE:    run = start_det;
      START:   run = !(sample_valid && sample_bit);
      STOP:    run = !sample_valid;
      default: run = 1'b1;
    endcase
  end

  uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
    .clk          (CLK),
    .rst_n        (RST),
    .run          (run),
    .rx           (rx_s),
    .sample_valid (sample_valid),
    .sample_bit   (sample_bit),
    .bit_end      (bit_end)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      cfg          <= '0;
      shreg        <= '0;
      bit_cnt      <= '0;
      par_fail     <= 1'b0;
      P_DATA       <= '0;
      DATA_VALID   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      DATA_VALID   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
      case (state)
        IDLE: if (start_det) begin
          state    <= START;
          cfg      <= Configuration;
          bit_cnt  <= '0;
          par_fail <= 1'b0;
          Busy     <= 1'b1;
        end
        START: begin
          if (sample_valid && sample_bit) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else if (bit_end) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (sample_valid) begin
            shreg   <= {sample_bit, shreg[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          // The last sample can share its cycle with bit_end at the smallest prescale.
          if (bit_end && (bit_cnt == ALL_BITS || (sample_valid && bit_cnt == LAST_BIT)))
            state <= cfg[CFG_PAR_EN] ? PARITY : STOP;
        end
        PARITY: begin
          if (sample_valid)
            par_fail <= (sample_bit != ((^shreg) ^ cfg[CFG_PAR_TYPE]));
          if (bit_end) state <= STOP;
        end
        STOP: if (sample_valid) begin
          state <= IDLE;
          Busy  <= 1'b0;
          if (!sample_bit || par_fail) begin
            Stop_Error   <= !sample_bit;
            Parity_Error <= par_fail;
          end else begin
            DATA_VALID <= 1'b1;
            P_DATA     <= shreg;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at PRESCALE = 8; honours UART_RX_MAJORITY_EN for latency and glitch cases.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int P = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 80;
`else
  localparam int LAT = 79;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [1:0] Configuration = 2'b00;
  logic [7:0] P_DATA;
  logic       DATA_VALID, Parity_Error, Stop_Error, Busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_start = 0;
  int dv_n = 0, pe_n = 0, se_n = 0;
  int dv_cyc = 0, dv_cyc_prev = 0;
  logic [7:0] dv_dat = 8'h00, dv_dat_prev = 8'h00;
  int b_dv, b_pe, b_se;

  uart_rx #(.PRESCALE(P)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .RX_IN         (RX_IN),
    .Configuration (Configuration),
    .P_DATA        (P_DATA),
    .DATA_VALID    (DATA_VALID),
    .Parity_Error  (Parity_Error),
    .Stop_Error    (Stop_Error),
    .Busy          (Busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (DATA_VALID === 1'b1) begin
      dv_n++;
      dv_cyc_prev = dv_cyc;
      dv_cyc      = cyc;
      dv_dat_prev = dv_dat;
      dv_dat      = P_DATA;
    end
    if (Parity_Error === 1'b1) pe_n++;
    if (Stop_Error === 1'b1) se_n++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic snap();
    b_dv = dv_n;
    b_pe = pe_n;
    b_se = se_n;
  endtask

  task automatic send_bit(input logic v, input bit glitch);
    for (int k = 0; k < P; k++) begin
      RX_IN = (glitch && k == P / 2) ? ~v : v;
      wait_cycles(1);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_en, input logic par_bit,
                            input logic stop_bit, input int glitch_idx);
    t_start = cyc;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch_idx == i);
    if (par_en) send_bit(par_bit, 1'b0);
    send_bit(stop_bit, 1'b0);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    wait_cycles(3);
    checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL reset_pdata: got %h want 00", P_DATA); end
    checks++; if (DATA_VALID !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", DATA_VALID); end
    checks++; if (Parity_Error !== 1'b0) begin errors++; $display("FAIL reset_pe: got %b want 0", Parity_Error); end
    checks++; if (Stop_Error !== 1'b0) begin errors++; $display("FAIL reset_se: got %b want 0", Stop_Error); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    RST = 1'b1;
    wait_cycles(3);
  endtask

  task automatic test_basic();
    Configuration = 2'b00;
    snap();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
    wait_cycles(4);
    checks++; if (dv_n !== b_dv + 1) begin errors++; $display("FAIL basic_dv_count: got %0d want %0d", dv_n - b_dv, 1); end
    checks++; if (P_DATA !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", P_DATA); end
    checks++; if (pe_n !== b_pe || se_n !== b_se) begin errors++; $display("FAIL basic_errors: got pe=%0d se=%0d want 0 0", pe_n - b_pe, se_n - b_se); end
    checks++; if (dv_cyc - t_start !== LAT) begin errors++; $display("FAIL basic_latency: got %0d want %0d", dv_cyc - t_start, LAT); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %b want 0", Busy); end
  endtask

  task automatic test_parity();
    Configuration = 2'b01;
    snap();
    send_frame(8'h37, 1'b1, 1'b1, 1'b1, -1);
    wait_cycles(4);
    checks++; if (dv_n !== b_dv + 1) begin errors++; $display("FAIL par_good_dv: got %0d want 1", dv_n - b_dv); end
    checks++; if (P_DATA !== 8'h37) begin errors++; $display("FAIL par_good_data: got %h want 37", P_DATA); end
    checks++; if (pe_n !== b_pe) begin errors++; $display("FAIL par_good_pe: got %0d want 0", pe_n - b_pe); end
    checks++; if (dv_cyc - t_start !== LAT + P) begin errors++; $display("FAIL par_latency: got %0d want %0d", dv_cyc - t_start, LAT + P); end
    snap();
    send_frame(8'h37, 1'b1, 1'b0, 1'b1, -1);
    wait_cycles(4);
    checks++; if (pe_n !== b_pe + 1) begin errors++; $display("FAIL par_bad_pe: got %0d want 1", pe_n - b_pe); end
    checks++; if (dv_n !== b_dv || se_n !== b_se) begin errors++; $display("FAIL par_bad_others: got dv=%0d se=%0d want 0 0", dv_n - b_dv, se_n - b_se); end
    checks++; if (P_DATA !== 8'h37) begin errors++; $display("FAIL par_bad_hold: got %h want 37", P_DATA); end
  endtask

  task automatic test_stop_error();
    Configuration = 2'b00;
    snap();
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, -1);
    wait_cycles(4);
    checks++; if (se_n !== b_se + 1) begin errors++; $display("FAIL stop_se: got %0d want 1", se_n - b_se); end
    checks++; if (dv_n !== b_dv || pe_n !== b_pe) begin errors++; $display("FAIL stop_others: got dv=%0d pe=%0d want 0 0", dv_n - b_dv, pe_n - b_pe); end
    checks++; if (P_DATA !== 8'h37) begin errors++; $display("FAIL stop_hold: got %h want 37", P_DATA); end
    snap();
    wait_cycles(20 * P);
    checks++; if (dv_n !== b_dv || pe_n !== b_pe || se_n !== b_se) begin errors++; $display("FAIL break_quiet: got dv=%0d pe=%0d se=%0d want 0 0 0", dv_n - b_dv, pe_n - b_pe, se_n - b_se); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL break_busy: got %b want 0", Busy); end
    RX_IN = 1'b1;
    wait_cycles(2 * P);
    snap();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1);
    wait_cycles(4);
    checks++; if (dv_n !== b_dv + 1) begin errors++; $display("FAIL recover_dv: got %0d want 1", dv_n - b_dv); end
    checks++; if (P_DATA !== 8'h5A) begin errors++; $display("FAIL recover_data: got %h want 5a", P_DATA); end
  endtask

  task automatic test_glitch();
    bit busy_seen;
    busy_seen = 1'b0;
    snap();
    RX_IN = 1'b0;
    wait_cycles(2);
    RX_IN = 1'b1;
    for (int i = 0; i < 2 * P; i++) begin
      wait_cycles(1);
      if (Busy === 1'b1) busy_seen = 1'b1;
    end
    checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse: got %b want 1", busy_seen); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b want 0", Busy); end
    checks++; if (dv_n !== b_dv || pe_n !== b_pe || se_n !== b_se) begin errors++; $display("FAIL glitch_quiet: got dv=%0d pe=%0d se=%0d want 0 0 0", dv_n - b_dv, pe_n - b_pe, se_n - b_se); end
`ifdef UART_RX_MAJORITY_EN
    Configuration = 2'b00;
    snap();
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 4);
    wait_cycles(4);
    checks++; if (dv_n !== b_dv + 1) begin errors++; $display("FAIL maj_dv: got %0d want 1", dv_n - b_dv); end
    checks++; if (P_DATA !== 8'h0F) begin errors++; $display("FAIL maj_data: got %h want 0f", P_DATA); end
`endif
  endtask

  task automatic test_back_to_back();
    Configuration = 2'b11;
    snap();
    send_frame(8'h11, 1'b1, 1'b1, 1'b1, -1);
    send_frame(8'hEE, 1'b1, 1'b1, 1'b1, -1);
    wait_cycles(4);
    checks++; if (dv_n !== b_dv + 2) begin errors++; $display("FAIL b2b_dv_count: got %0d want 2", dv_n - b_dv); end
    checks++; if (dv_dat_prev !== 8'h11) begin errors++; $display("FAIL b2b_first: got %h want 11", dv_dat_prev); end
    checks++; if (dv_dat !== 8'hEE) begin errors++; $display("FAIL b2b_second: got %h want ee", dv_dat); end
    checks++; if (dv_cyc - dv_cyc_prev !== 11 * P) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", dv_cyc - dv_cyc_prev, 11 * P); end
    checks++; if (pe_n !== b_pe || se_n !== b_se) begin errors++; $display("FAIL b2b_errors: got pe=%0d se=%0d want 0 0", pe_n - b_pe, se_n - b_se); end
  endtask

  task automatic test_reset_mid();
    Configuration = 2'b00;
    wait_cycles(P);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    wait_cycles(P / 2);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", Busy); end
    RST = 1'b0;
    #1;
    checks++; if (Busy !== 1'b0 || DATA_VALID !== 1'b0 || Parity_Error !== 1'b0 || Stop_Error !== 1'b0)
      begin errors++; $display("FAIL mid_reset_flags: got busy=%b dv=%b pe=%b se=%b want 0 0 0 0", Busy, DATA_VALID, Parity_Error, Stop_Error); end
    checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL mid_reset_pdata: got %h want 00", P_DATA); end
    snap();
    RX_IN = 1'b1;
    wait_cycles(3);
    RST = 1'b1;
    wait_cycles(2 * P);
    checks++; if (dv_n !== b_dv || pe_n !== b_pe || se_n !== b_se) begin errors++; $display("FAIL mid_abort_quiet: got dv=%0d pe=%0d se=%0d want 0 0 0", dv_n - b_dv, pe_n - b_pe, se_n - b_se); end
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1);
    wait_cycles(4);
    checks++; if (dv_n !== b_dv + 1) begin errors++; $display("FAIL mid_next_dv: got %0d want 1", dv_n - b_dv); end
    checks++; if (P_DATA !== 8'h3C) begin errors++; $display("FAIL mid_next_data: got %h want 3c", P_DATA); end
    checks++; if (pe_n !== b_pe || se_n !== b_se) begin errors++; $display("FAIL mid_next_errors: got pe=%0d se=%0d want 0 0", pe_n - b_pe, se_n - b_se); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, the receiving end of the team's UART transmitter link. It synchronises and oversamples the serial line, detects the start bit, and deserialises 8 data bits LSB-first. It checks the optional parity bit and the stop bit, then presents the byte on a one-cycle valid strobe. It sits between the external RX pin and the system-side consumer (register file / ALU command decoder).

## Interface
- PRESCALE, 8: CLK cycles per serial bit; even, ≥ 4.
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  reset, asynchronous, active-low; clears all state and outputs.
- RX_IN  input  1  serial line; idle high; asynchronous to CLK.
- Configuration  input  2  [0] parity enable, [1] parity type (0 even, 1 odd); latched at start-bit detection.
- P_DATA  output  8  received byte; updated only when DATA_VALID is asserted, held otherwise.
- DATA_VALID  output  1  one-cycle pulse: good frame, P_DATA valid.
- Parity_Error  output  1  one-cycle pulse: parity mismatch.
- Stop_Error  output  1  one-cycle pulse: stop bit sampled low.
- Busy  output  1  high from start detection until return to IDLE.

## Operation
- Frame format: start (0), D0..D7 LSB-first, optional parity, stop (1).
- RX_IN passes through a 2-flop synchroniser. All timing below is relative to the synchronised signal rx_s.
- Edge counter runs 0..PRESCALE-1 within each bit. Bit counter tracks position in the frame.
- Sample point: counter == PRESCALE/2 (single-sample build). Majority build: see Configuration.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: a falling edge on rx_s (previous 1, current 0) moves to START. Counter is 0 in that cycle. Configuration is latched. Busy rises.
- START: sample = 1 is a false start; return to IDLE with no outputs. Sample = 0 means stay until counter == PRESCALE-1, then go to DATA.
- DATA: at each sample point, shift the sample into bit 7 of the shift register (right shift). After 8 bits, go to PARITY if enabled, otherwise STOP.
- PARITY: expected bit = XOR(data) XOR Configuration[1]. A mismatch sets the internal parity-fail flag.
- STOP: at the sample point, evaluate the frame and go to IDLE on the next cycle. The FSM does not wait for the end of the bit, which gives a half-bit margin for back-to-back frames.
- Frame evaluation, registered, in the cycle after the stop decision:
  - Good frame: DATA_VALID = 1, P_DATA = shift register.
  - Parity fail: Parity_Error = 1.
  - Stop bit = 0: Stop_Error = 1.
  - Both errors may pulse in the same cycle. DATA_VALID never pulses with an error, and P_DATA holds its previous value.
- Line held low (break): reported as a Stop_Error. The next frame requires rx_s high before a new falling edge is accepted.
- Configuration changes mid-frame have no effect until the next start.

## Timing
- Reset values: P_DATA = 0x00; DATA_VALID, Parity_Error, Stop_Error, Busy = 0; FSM = IDLE; synchroniser flops = 1.
- Reset asserted mid-frame: the frame is aborted immediately, with no strobe.
- t0 = first cycle with rx_s = 0 after a 1.
- Stop bit index N = 9 without parity, 10 with parity.
- Stop decision cycle = t0 + N·PRESCALE + PRESCALE/2 (+1 in the majority build).
- DATA_VALID or error pulse = decision cycle + 1.
- Busy falls in the same cycle the pulse asserts.
- Example, PRESCALE = 8, no parity, single-sample: pulse at t0+77.
- Pin-to-output latency adds 2 cycles for the synchroniser.
- Strobes are exactly one cycle wide. There is no backpressure; the consumer must take P_DATA on DATA_VALID.

## Configuration
- UART_RX_MAJORITY_EN defined: each bit value is the 2-of-3 majority of samples at counter PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. The decision is made at PRESCALE/2+1, which rejects single-cycle glitches.
- UART_RX_MAJORITY_EN undefined: single sample at PRESCALE/2. All decision points are one cycle earlier.

## Structure
- Package uart_pkg holds:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP);
  - the Configuration bit indices CFG_PAR_EN = 0 and CFG_PAR_TYPE = 1;
  - DATA_WIDTH = 8.
- The same package is to be shared with the transmitter.
- Sub-module uart_rx_sampler holds the edge counter, the sample-point strobe and the majority logic. It outputs sample_valid, sample_bit and bit_end.
- The top level holds the synchroniser, FSM, shift register, parity check and output registers.

## Test plan
- PRESCALE = 8, no parity, send 0xA5 with stop = 1 → single DATA_VALID at t0+77 (t0+78 in the majority build), P_DATA = 0xA5, no errors.
- Even parity, send 0x37 with parity bit 1 → DATA_VALID, P_DATA = 0x37. Repeat with parity bit 0 → Parity_Error only, P_DATA still 0x37 held from before.
- Send 0x00 with stop bit 0 → Stop_Error only. Keep the line low for 20 bits → no further strobes. Release, then send 0x5A → DATA_VALID, P_DATA = 0x5A.
- Low glitch of 2 cycles on an idle line → Busy pulses briefly, then returns to IDLE with no strobe. Majority build: 1-cycle glitch at a data sample point → byte still correct.
- Two back-to-back frames 0x11 and 0xEE, odd parity, no idle gap → two DATA_VALID pulses spaced 11·PRESCALE cycles apart, with correct bytes.
- Assert RST at bit 4 of a frame → all outputs 0 immediately. A following 0x3C frame → received correctly.
